// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged board reset sequencer.
// The optional long-press reconfigure feature is selected with the
// RESET_SEQ_LONGPRESS_EN macro in reset_sequencer.sv.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam logic [1:0] CAUSE_EXT = 2'd0;
    localparam logic [1:0] CAUSE_PLL = 2'd1;
    localparam logic [1:0] CAUSE_BTN = 2'd2;
    localparam logic [1:0] CAUSE_SW  = 2'd3;

    // Priority encode simultaneous causes: PLL loss beats button beats software.
    function automatic logic [1:0] cause_encode(input logic pll_lost,
                                                input logic btn,
                                                input logic sw);
        logic [1:0] code;
        if (pll_lost) begin
            code = CAUSE_PLL;
        end else if (btn) begin
            code = CAUSE_BTN;
        end else if (sw) begin
            code = CAUSE_SW;
        end else begin
            code = CAUSE_EXT;
        end
        return code;
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// The debounced output only changes after the synchronised input has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
module reset_debounce
    import reset_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65535
) (
    input  logic clk,
    input  logic n_reset,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_r;
    logic             sync2_r;
    logic             db_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    assign cnt_next_s = cnt_r + CNT_W'(1);
    assign dout       = db_r;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Count while the input disagrees with the accepted value; flip once stable long enough.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_r <= '0;
            db_r  <= 1'b0;
        end else if (sync2_r != db_r) begin
            if (cnt_next_s == CNT_LAST) begin
                cnt_r <= '0;
                db_r  <= sync2_r;
            end else begin
                cnt_r <= cnt_next_s;
                db_r  <= db_r;
            end
        end else begin
            cnt_r <= '0;
            db_r  <= db_r;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged board reset sequencer: merges PLL loss, debounced button and
// software request into one hold period, then releases nreset_out bit by
// bit (bit 0 first). Defining RESET_SEQ_LONGPRESS_EN adds a one-cycle
// reconfigure pulse after a long debounced button press.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned STAGES           = 3,
    parameter int unsigned RESET_CYCLES     = 131071,
    parameter int unsigned STAGE_GAP        = 1024,
    parameter int unsigned DEBOUNCE_CYCLES  = 65535,
    parameter int unsigned LONGPRESS_CYCLES = 33554431
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              pll_locked,
    input  logic              button,
    input  logic              sw_reset_req,
    output logic [STAGES-1:0] nreset_out,
    output logic [1:0]        reset_cause,
    output logic              reconfigure
);

    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES) + 1;
    localparam int unsigned GAP_W  = $clog2(STAGE_GAP) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    // First-stage pattern; with a single stage it is already the full mask.
    localparam logic [STAGES-1:0] STAGE_ONE = STAGES'(1'b1);

    seq_state_t        state_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [STAGES-1:0] nreset_out_r;
    logic [1:0]        reset_cause_r;
    logic              pll_sync1_r;
    logic              pll_sync2_r;
    logic              btn_db_s;
    logic              cause_active_s;
    logic [STAGES-1:0] release_next_s;

    assign nreset_out     = nreset_out_r;
    assign reset_cause    = reset_cause_r;
    assign cause_active_s = !pll_sync2_r || btn_db_s || sw_reset_req;
    assign release_next_s = (nreset_out_r << 1'b1) | STAGE_ONE;

    reset_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .n_reset(n_reset),
        .din    (button),
        .dout   (btn_db_s)
    );

    // Synchronise the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pll_sync1_r <= 1'b0;
            pll_sync2_r <= 1'b0;
        end else begin
            pll_sync1_r <= pll_locked;
            pll_sync2_r <= pll_sync1_r;
        end
    end

    // Hold / staged-release / run state machine with registered outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r       <= HOLD;
            hold_cnt_r    <= '0;
            gap_cnt_r     <= '0;
            nreset_out_r  <= '0;
            reset_cause_r <= CAUSE_EXT;
        end else begin
            case (state_r)
                HOLD: begin
                    gap_cnt_r <= '0;
                    if (cause_active_s) begin
                        hold_cnt_r <= '0;
                    end else if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_r   <= '0;
                        nreset_out_r <= STAGE_ONE;
                        state_r      <= STAGE_ONE[STAGES-1] ? RUN : RELEASE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (cause_active_s) begin
                        state_r       <= HOLD;
                        hold_cnt_r    <= '0;
                        gap_cnt_r     <= '0;
                        nreset_out_r  <= '0;
                        reset_cause_r <= cause_encode(!pll_sync2_r, btn_db_s, sw_reset_req);
                    end else if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r    <= '0;
                        nreset_out_r <= release_next_s;
                        state_r      <= release_next_s[STAGES-1] ? RUN : RELEASE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                RUN: begin
                    if (cause_active_s) begin
                        state_r       <= HOLD;
                        hold_cnt_r    <= '0;
                        gap_cnt_r     <= '0;
                        nreset_out_r  <= '0;
                        reset_cause_r <= cause_encode(!pll_sync2_r, btn_db_s, sw_reset_req);
                    end else begin
                        nreset_out_r <= '1;
                    end
                end
                default: begin
                    state_r      <= HOLD;
                    hold_cnt_r   <= '0;
                    gap_cnt_r    <= '0;
                    nreset_out_r <= '0;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_LONGPRESS_EN
    localparam int unsigned PRESS_W = $clog2(LONGPRESS_CYCLES) + 1;
    localparam logic [PRESS_W-1:0] PRESS_LAST = PRESS_W'(LONGPRESS_CYCLES);

    logic [PRESS_W-1:0] press_cnt_r;
    logic               reconfigure_r;

    assign reconfigure = reconfigure_r;

    // Time the debounced press; pulse once as the count reaches its saturation value.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            press_cnt_r   <= '0;
            reconfigure_r <= 1'b0;
        end else if (!btn_db_s) begin
            press_cnt_r   <= '0;
            reconfigure_r <= 1'b0;
        end else if (press_cnt_r != PRESS_LAST) begin
            press_cnt_r   <= press_cnt_r + PRESS_W'(1);
            reconfigure_r <= (press_cnt_r == PRESS_LAST - PRESS_W'(1));
        end else begin
            press_cnt_r   <= press_cnt_r;
            reconfigure_r <= 1'b0;
        end
    end
`else
    assign reconfigure = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge, so
// step(n) advances exactly n rising (active) edges.
module tb_reset_sequencer;

    localparam int unsigned STAGES = 3;

    logic              clk;
    logic              n_reset;
    logic              pll_locked;
    logic              button;
    logic              sw_reset_req;
    logic [STAGES-1:0] nreset_out;
    logic [1:0]        reset_cause;
    logic              reconfigure;

    int total_cnt;
    int bad_cnt;
    int pulse_cnt;
    int edge_cnt;
    bit counting_en;

    reset_sequencer #(
        .STAGES          (STAGES),
        .RESET_CYCLES    (100),
        .STAGE_GAP       (10),
        .DEBOUNCE_CYCLES (8),
        .LONGPRESS_CYCLES(500)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .pll_locked  (pll_locked),
        .button      (button),
        .sw_reset_req(sw_reset_req),
        .nreset_out  (nreset_out),
        .reset_cause (reset_cause),
        .reconfigure (reconfigure)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count reconfigure pulses seen away from the active edge.
    always @(negedge clk) begin
        if (counting_en && reconfigure) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        total_cnt    = 0;
        bad_cnt      = 0;
        pulse_cnt    = 0;
        counting_en  = 1'b0;
        n_reset      = 1'b0;
        pll_locked   = 1'b1;
        button       = 1'b0;
        sw_reset_req = 1'b0;

        // Power-up: outputs held while n_reset is low.
        step(5);
        chk("rst_nreset", 32'(nreset_out), 32'h0);
        chk("rst_cause", 32'(reset_cause), 32'h0);
        chk("rst_reconf", 32'(reconfigure), 32'h0);
        n_reset     = 1'b1;
        counting_en = 1'b1;

        // Bit 0 at edge 102, bit 1 at 112, bit 2 at 122.
        step(101);
        chk("pu_e101", 32'(nreset_out), 32'h0);
        step(1);
        chk("pu_e102", 32'(nreset_out), 32'h1);
        step(9);
        chk("pu_e111", 32'(nreset_out), 32'h1);
        step(1);
        chk("pu_e112", 32'(nreset_out), 32'h3);
        step(9);
        chk("pu_e121", 32'(nreset_out), 32'h3);
        step(1);
        chk("pu_e122", 32'(nreset_out), 32'h7);
        chk("pu_cause", 32'(reset_cause), 32'h0);

        // PLL drop for 20 cycles: reset within 3 edges, resume 102 edges after relock.
        pll_locked = 1'b0;
        step(2);
        chk("pll_e2", 32'(nreset_out), 32'h7);
        step(1);
        chk("pll_e3", 32'(nreset_out), 32'h0);
        chk("pll_cause", 32'(reset_cause), 32'h1);
        step(17);
        pll_locked = 1'b1;
        step(101);
        chk("pll_re101", 32'(nreset_out), 32'h0);
        step(1);
        chk("pll_re102", 32'(nreset_out), 32'h1);
        step(20);
        chk("pll_run", 32'(nreset_out), 32'h7);

        // Short button glitch is ignored.
        button = 1'b1;
        step(5);
        button = 1'b0;
        step(30);
        chk("glitch_out", 32'(nreset_out), 32'h7);
        chk("glitch_cause", 32'(reset_cause), 32'h1);

        // 20-cycle press: accepted after sync + debounce.
        button = 1'b1;
        step(8);
        chk("btn_e8", 32'(nreset_out), 32'h7);
        step(4);
        chk("btn_e12", 32'(nreset_out), 32'h0);
        chk("btn_cause", 32'(reset_cause), 32'h2);
        step(8);
        button = 1'b0;
        // Release: 2 sync + 8 debounce edges, then 100 hold edges.
        edge_cnt = 0;
        while (nreset_out[0] !== 1'b1 && edge_cnt < 300) begin
            step(1);
            edge_cnt++;
        end
        chk("btn_rel_win", 32'(edge_cnt >= 109 && edge_cnt <= 111), 32'h1);
        step(20);
        chk("btn_run", 32'(nreset_out), 32'h7);

        // Simultaneous causes, aligned at the sequencer: PLL loss (after its
        // two synchroniser edges) and a software request hit the same edge.
        pll_locked = 1'b0;
        step(2);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        chk("sim_out", 32'(nreset_out), 32'h0);
        chk("sim_cause", 32'(reset_cause), 32'h1);
        step(5);
        pll_locked = 1'b1;
        step(50);
        // Software request 50 cycles into hold restarts the count.
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        chk("hold_sw_cause", 32'(reset_cause), 32'h1);
        step(99);
        chk("hold_sw_e99", 32'(nreset_out), 32'h0);
        step(1);
        chk("hold_sw_e100", 32'(nreset_out), 32'h1);
        step(10);
        chk("mid_011", 32'(nreset_out), 32'h3);

        // Mid-release software request.
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        chk("mid_out", 32'(nreset_out), 32'h0);
        chk("mid_cause", 32'(reset_cause), 32'h3);
        step(99);
        chk("mid_e99", 32'(nreset_out), 32'h0);
        step(1);
        chk("mid_e100", 32'(nreset_out), 32'h1);
        step(20);
        chk("mid_run", 32'(nreset_out), 32'h7);

        // Long press: held in reset throughout; reconfigure only with the feature.
        pulse_cnt = 0;
        button    = 1'b1;
        step(600);
        chk("lp_out", 32'(nreset_out), 32'h0);
        chk("lp_cause", 32'(reset_cause), 32'h2);
`ifdef RESET_SEQ_LONGPRESS_EN
        chk("lp_pulses", 32'(pulse_cnt), 32'h1);
`else
        chk("lp_pulses", 32'(pulse_cnt), 32'h0);
`endif
        button = 1'b0;
        step(30);
        chk("lp_rel_hold", 32'(nreset_out), 32'h0);

        // Asynchronous reset clears outputs immediately.
        #2;
        n_reset = 1'b0;
        #1;
        chk("arst_out", 32'(nreset_out), 32'h0);
        chk("arst_cause", 32'(reset_cause), 32'h0);
        chk("arst_reconf", 32'(reconfigure), 32'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
